shift_receiver: RTL and testbench
=================================

# shift_receiver

Serial-to-parallel receiving end of the 8-bit shift-register link: accepts one bit per strobed clock edge from a serial line, assembles W-bit words in LSB-first or MSB-first order, and presents each completed word on a valid/ready parallel output. It sits at the far end of the serializer, between the serial wire and any parallel consumer, and buffers one word so the consumer may stall for up to one frame time.

## Interface
- W, default 8: word width in bits; legal range 2..32.
- c  input  1  clock; all state changes on the rising edge.
- nrst  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sen  input  1  bit strobe; sin is accepted on an edge where sen=1.
- sfrm  input  1  frame start; meaningful only with sen=1 and marks that bit as the first bit of a frame.
- dir  input  1  bit order; 0 = LSB first, 1 = MSB first; sampled only on an accepted sfrm bit.
- q  output  W  received word.
- qv  output  1  q holds a valid word.
- qr  input  1  consumer ready; the word transfers on an edge with qv=1 and qr=1.
- ovf  output  1  one-cycle pulse when a completed word is dropped.
- ferr  output  1  one-cycle pulse when a frame is aborted by an early sfrm.
- perr  output  1  one-cycle pulse when parity fails; held 0 without PARITY_EN.

## Operation
- State machine with states IDLE, DATA and PAR; PAR exists only with PARITY_EN.
- IDLE: an edge with sen=1 and sfrm=0 is ignored. An edge with sen=1 and sfrm=1 stores sin as bit 0, latches dir, sets cnt=1 and moves to DATA.
- DATA: each edge with sen=1 and sfrm=0 shifts sin in and increments cnt. An edge with sen=0 holds all state, with no timeout.
- Bit order: with dir=0 the register shifts right and inserts at the MSB, so the first bit lands in q[0]. With dir=1 it shifts left and inserts at the LSB, so the first bit lands in q[W-1].
- Word completion: the edge that accepts bit W-1 finishes the word. Without PARITY_EN the word goes to completion handling and the FSM returns to IDLE. With PARITY_EN the FSM moves to PAR.
- PAR: the next accepted bit is the parity bit and parity is even (XOR of the W data bits and the parity bit must be 0). On a match the word goes to completion handling. On a mismatch the word is discarded and perr pulses. Either way the FSM returns to IDLE.
- Completion handling:
  - The word loads into q and qv is set if the output register is empty (qv=0) or drains on the same edge (qv and qr both 1).
  - Otherwise the new word is dropped, ovf pulses, and q and qv are unchanged.
- sfrm with sen=1 in DATA or PAR: the partial frame is discarded, ferr pulses, and the bit restarts a frame exactly as from IDLE with cnt=1. No word is emitted.
- The output register clears qv on an edge with qv=1 and qr=1 unless a new word loads on the same edge.
- cnt width is $clog2(W+1) and cnt is cleared on every frame end or abort.

## Timing
- Reset values: q=0, qv=0, ovf=0, ferr=0, perr=0; state IDLE, cnt=0, shift register 0.
- Reset asserted mid-frame or with qv=1 discards everything immediately, with no pulse on ovf, ferr or perr.
- Latency: qv rises on the edge that accepts the last bit of a frame (the last data bit without parity, the parity bit with it). The word is visible the cycle after that bit is presented.
- ovf, ferr and perr are registered and each is high for exactly one cycle per event.
- Throughput: back-to-back frames are accepted at one bit per cycle. An sfrm bit immediately following the last bit of the previous frame is legal and is not an error.
- qv never depends combinationally on qr. The consumer may hold qr=1 permanently.

## Configuration
- SHIFT_RECEIVER_PARITY_EN defined:
  - Each frame is W data bits plus one even-parity bit.
  - The PAR state and the perr logic are present.
  - Frame length is W+1 accepted bits.
- Not defined:
  - Frames are W bits.
  - PAR is absent and perr is tied to 0.

## Structure
- Package shift_receiver_pkg holds:
  - the state typedef (IDLE, DATA, PAR);
  - constants DIR_LSB_FIRST=1'b0 and DIR_MSB_FIRST=1'b1.
- Sub-module rx_shreg: a W-bit bidirectional shift register with a clear input, an enable input, a direction input, serial input sin and parallel output. The top level contains the FSM, cnt, the output register and the pulse flags.

## Test plan
- W=8, dir=0, bits 1,0,1,1,0,0,0,0 with sfrm on the first bit, qr=1 -> q=8'h0D and qv high for one cycle, with qv rising on the 8th accepted edge.
- Same bits with dir=1 -> q=8'hB0.
- qr=0, two complete frames 8'hA5 then 8'h3C -> q stays 8'hA5 with qv=1 and ovf pulses once at the end of the second frame. Then qr=1 for one cycle -> qv=0.
- sfrm reasserted after 5 bits, then a full 8-bit frame 8'hFF -> ferr pulses once on the restart edge, and q=8'hFF is delivered.
- nrst pulled low after 4 bits of a frame -> all outputs 0 immediately, and the next full frame is received correctly.
- PARITY_EN: 8'h07 with parity bit 1 -> delivered, perr=0. 8'h07 with parity bit 0 -> qv stays 0 and perr pulses once.

Source files
------------

// File: rtl/shift_receiver_pkg.sv
// Shared types and constants for the shift_receiver serial-to-parallel block.
package shift_receiver_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t DATA = 2'd1;
    localparam state_t PAR  = 2'd2;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_receiver_if.sv
// Serial input and parallel valid/ready output bundle of shift_receiver.
interface shift_receiver_if #(
    parameter int unsigned W = 8
);
    logic         sin;
    logic         sen;
    logic         sfrm;
    logic         dir;
    logic [W-1:0] q;
    logic         qv;
    logic         qr;
    logic         ovf;
    logic         ferr;
    logic         perr;

    modport slave (
        input  sin, sen, sfrm, dir, qr,
        output q, qv, ovf, ferr, perr
    );

    modport master (
        output sin, sen, sfrm, dir, qr,
        input  q, qv, ovf, ferr, perr
    );
endinterface

// File: rtl/shift_receiver_rx_shreg.sv
// W-bit bidirectional shift register; word_c is the register value after this edge.
module rx_shreg
    import shift_receiver_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         dir,
    input  logic         sin,
    output logic [W-1:0] word_c
);

    logic [W-1:0] sh_q;
    logic [W-1:0] base;
    logic [W-1:0] shifted;

    // clr with en starts a fresh word whose first bit is sin
    always_comb begin
        base    = clr ? '0 : sh_q;
        shifted = base;
        case (dir)
            DIR_LSB_FIRST: shifted = {sin, base[W-1:1]};
            DIR_MSB_FIRST: shifted = {base[W-2:0], sin};
        endcase
        word_c  = en ? shifted : sh_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (en) begin
            sh_q <= shifted;
        end else if (clr) begin
            sh_q <= '0;
        end
    end

endmodule

// File: rtl/shift_receiver.sv
// Serial-to-parallel receiver with a one-word output buffer.
// Build option: SHIFT_RECEIVER_PARITY_EN adds an even-parity bit per frame.
module shift_receiver
    import shift_receiver_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             c,
    input  logic             nrst,
    shift_receiver_if.slave  bus
);

    localparam int unsigned CW = $clog2(W + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dir_q, dir_nxt;
    logic          start;
    logic          sh_clr, sh_en, sh_dir;
    logic [W-1:0]  sh_word;
    logic          done;
    logic [W-1:0]  q_q, q_nxt;
    logic          qv_q, qv_nxt;
    logic          ovf_q, ovf_nxt;
    logic          ferr_q, ferr_nxt;
    logic          perr_q, perr_nxt;

    assign start  = bus.sen & bus.sfrm;
    // the frame-start bit must use the incoming order, later bits the latched one
    assign sh_dir = start ? bus.dir : dir_q;

    rx_shreg #(.W(W)) u_shreg (
        .clk    (c),
        .rst_n  (nrst),
        .clr    (sh_clr),
        .en     (sh_en),
        .dir    (sh_dir),
        .sin    (bus.sin),
        .word_c (sh_word)
    );

    always_ff @(posedge c or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_q  <= 1'b0;
            q_q    <= '0;
            qv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dir_q  <= dir_nxt;
            q_q    <= q_nxt;
            qv_q   <= qv_nxt;
            ovf_q  <= ovf_nxt;
            ferr_q <= ferr_nxt;
            perr_q <= perr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        sh_clr    = 1'b0;
        sh_en     = 1'b0;
        done      = 1'b0;
        ferr_nxt  = 1'b0;
        perr_nxt  = 1'b0;
        q_nxt     = q_q;
        qv_nxt    = qv_q & ~bus.qr;
        ovf_nxt   = 1'b0;

        if (start) begin
            ferr_nxt  = (state != IDLE);
            sh_clr    = 1'b1;
            sh_en     = 1'b1;
            dir_nxt   = bus.dir;
            cnt_nxt   = CW'(1);
            state_nxt = DATA;
        end else begin
            case (state)
                DATA: begin
                    if (bus.sen) begin
                        sh_en = 1'b1;
                        if (cnt == CW'(W - 1)) begin
`ifdef SHIFT_RECEIVER_PARITY_EN
                            cnt_nxt   = CW'(W);
                            state_nxt = PAR;
`else
                            done      = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
`endif
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                PAR: begin
`ifdef SHIFT_RECEIVER_PARITY_EN
                    if (bus.sen) begin
                        if (^{sh_word, bus.sin}) perr_nxt = 1'b1;
                        else                     done     = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
`else
                    // unreachable without parity; recover to IDLE
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
`endif
                end
                default: ;
            endcase
        end

        // a full buffer may still accept a word if it drains on this edge
        if (done) begin
            if (!qv_q || bus.qr) begin
                q_nxt  = sh_word;
                qv_nxt = 1'b1;
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    assign bus.q    = q_q;
    assign bus.qv   = qv_q;
    assign bus.ovf  = ovf_q;
    assign bus.ferr = ferr_q;
    assign bus.perr = perr_q;

endmodule

// File: tb/tb_shift_receiver.sv
// Self-checking bench for shift_receiver (frame-level reference model).
module tb_shift_receiver;

    localparam int unsigned W = 8;
`ifdef SHIFT_RECEIVER_PARITY_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    logic c = 1'b0;
    logic nrst;
    always #5 c = ~c;

    shift_receiver_if #(.W(W)) bus ();

    shift_receiver #(.W(W)) dut (
        .c    (c),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // reference model state: bits of the open frame, the output slot, pulses
    bit           bits[$];
    logic         fdir;
    logic [W-1:0] exp_q;
    logic         exp_qv;
    logic         e_ovf, e_ferr, e_perr;

    // i-th serial bit of a frame carrying word w; index W is the even-parity bit
    function automatic logic ser_bit(logic [W-1:0] w, logic d, int i);
        if (i >= int'(W)) return ^w;
        return d ? w[int'(W) - 1 - i] : w[i];
    endfunction

    task automatic model_clear();
        bits.delete();
        fdir   = 1'b0;
        exp_q  = '0;
        exp_qv = 1'b0;
        e_ovf  = 1'b0;
        e_ferr = 1'b0;
        e_perr = 1'b0;
    endtask

    task automatic cycle(input logic sen, input logic sin, input logic sfrm,
                         input logic dir, input logic qr);
        logic         done;
        logic [W-1:0] word;
        int           ones;
        @(negedge c);
        bus.sen  = sen;
        bus.sin  = sin;
        bus.sfrm = sfrm;
        bus.dir  = dir;
        bus.qr   = qr;
        @(posedge c);
        done   = 1'b0;
        word   = '0;
        e_ovf  = 1'b0;
        e_ferr = 1'b0;
        e_perr = 1'b0;
        if (sen) begin
            if (sfrm) begin
                e_ferr = (bits.size() != 0);
                bits.delete();
                bits.push_back(sin);
                fdir = dir;
            end else if (bits.size() != 0) begin
                bits.push_back(sin);
            end
            if (bits.size() == int'(FL)) begin
                ones = 0;
                for (int i = 0; i < int'(FL); i++) ones += int'(bits[i]);
                for (int i = 0; i < int'(W); i++) begin
                    if (fdir) word[int'(W) - 1 - i] = bits[i];
                    else      word[i] = bits[i];
                end
                if (FL > W && (ones % 2) != 0) e_perr = 1'b1;
                else                           done   = 1'b1;
                bits.delete();
            end
        end
        if (done) begin
            if (!exp_qv || qr) begin
                exp_q  = word;
                exp_qv = 1'b1;
            end else begin
                e_ovf = 1'b1;
            end
        end else if (exp_qv && qr) begin
            exp_qv = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.sen = 1'b0; bus.sin = 1'b0; bus.sfrm = 1'b0; bus.dir = 1'b0; bus.qr = 1'b0;
        model_clear();
        #12;
        total++;
        if ({bus.q, bus.qv, bus.ovf, bus.ferr, bus.perr} !== '0) begin
            bad++;
            $display("FAIL reset: q=%h qv=%b ovf=%b ferr=%b perr=%b, want all 0",
                     bus.q, bus.qv, bus.ovf, bus.ferr, bus.perr);
        end
        @(negedge c);
        nrst = 1'b1;
    endtask

    task automatic test_order(input logic d, input logic [W-1:0] want);
        for (int i = 0; i < int'(FL) - 1; i++)
            cycle(1'b1, ser_bit(8'h0D ^ 8'h0D ^ want, d, i), (i == 0), d, 1'b1);
        total++;
        if (bus.qv !== 1'b0) begin
            bad++;
            $display("FAIL order%0d early_qv: qv=%b want 0", d, bus.qv);
        end
        cycle(1'b1, ser_bit(want, d, int'(FL) - 1), 1'b0, d, 1'b1);
        total++;
        if (bus.qv !== 1'b1 || bus.q !== want) begin
            bad++;
            $display("FAIL order%0d word: qv=%b q=%h want qv=1 q=%h", d, bus.qv, bus.q, want);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.qv !== 1'b0) begin
            bad++;
            $display("FAIL order%0d drain: qv=%b want 0", d, bus.qv);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < int'(FL); i++) cycle(1'b1, ser_bit(8'hA5, 1'b0, i), (i == 0), 1'b0, 1'b0);
        total++;
        if (bus.qv !== 1'b1 || bus.q !== 8'hA5) begin
            bad++;
            $display("FAIL ovf first: qv=%b q=%h want qv=1 q=a5", bus.qv, bus.q);
        end
        for (int i = 0; i < int'(FL); i++) begin
            cycle(1'b1, ser_bit(8'h3C, 1'b0, i), (i == 0), 1'b0, 1'b0);
            total++;
            if (bus.ovf !== (i == int'(FL) - 1)) begin
                bad++;
                $display("FAIL ovf pulse bit%0d: ovf=%b want %b", i, bus.ovf, (i == int'(FL) - 1));
            end
        end
        total++;
        if (bus.qv !== 1'b1 || bus.q !== 8'hA5) begin
            bad++;
            $display("FAIL ovf hold: qv=%b q=%h want qv=1 q=a5", bus.qv, bus.q);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.qv !== 1'b0 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf drain: qv=%b ovf=%b want 0 0", bus.qv, bus.ovf);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 5; i++) cycle(1'b1, ser_bit(8'h5A, 1'b0, i), (i == 0), 1'b0, 1'b1);
        cycle(1'b1, ser_bit(8'hFF, 1'b0, 0), 1'b1, 1'b0, 1'b1);
        total++;
        if (bus.ferr !== 1'b1 || bus.qv !== 1'b0) begin
            bad++;
            $display("FAIL abort pulse: ferr=%b qv=%b want 1 0", bus.ferr, bus.qv);
        end
        for (int i = 1; i < int'(FL); i++) begin
            cycle(1'b1, ser_bit(8'hFF, 1'b0, i), 1'b0, 1'b0, 1'b1);
            total++;
            if (bus.ferr !== 1'b0) begin
                bad++;
                $display("FAIL abort ferr_once bit%0d: ferr=%b want 0", i, bus.ferr);
            end
        end
        total++;
        if (bus.qv !== 1'b1 || bus.q !== 8'hFF) begin
            bad++;
            $display("FAIL abort word: qv=%b q=%h want qv=1 q=ff", bus.qv, bus.q);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < int'(FL); i++) cycle(1'b1, ser_bit(8'h81, 1'b0, i), (i == 0), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, ser_bit(8'h66, 1'b1, i), (i == 0), 1'b1, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        model_clear();
        total++;
        if ({bus.q, bus.qv, bus.ovf, bus.ferr, bus.perr} !== '0) begin
            bad++;
            $display("FAIL midreset: q=%h qv=%b ovf=%b ferr=%b perr=%b, want all 0",
                     bus.q, bus.qv, bus.ovf, bus.ferr, bus.perr);
        end
        @(negedge c);
        nrst = 1'b1;
        for (int i = 0; i < int'(FL); i++) begin
            cycle(1'b1, ser_bit(8'hC3, 1'b1, i), (i == 0), 1'b1, 1'b1);
            total++;
            if (bus.ferr !== 1'b0 || bus.qv !== (i == int'(FL) - 1)) begin
                bad++;
                $display("FAIL midreset frame bit%0d: ferr=%b qv=%b", i, bus.ferr, bus.qv);
            end
        end
        total++;
        if (bus.q !== 8'hC3) begin
            bad++;
            $display("FAIL midreset word: q=%h want c3", bus.q);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w [3];
        w[0] = 8'h12; w[1] = 8'hE7; w[2] = 8'h40;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < int'(FL); i++) begin
                cycle(1'b1, ser_bit(w[f], f[0], i), (i == 0), f[0], 1'b1);
                total++;
                if (bus.ferr !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b ferr f%0d bit%0d: ferr=%b want 0", f, i, bus.ferr);
                end
            end
            total++;
            if (bus.qv !== 1'b1 || bus.q !== w[f]) begin
                bad++;
                $display("FAIL b2b word f%0d: qv=%b q=%h want qv=1 q=%h", f, bus.qv, bus.q, w[f]);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef SHIFT_RECEIVER_PARITY_EN
    task automatic test_parity();
        for (int i = 0; i < int'(W); i++) cycle(1'b1, ser_bit(8'h07, 1'b0, i), (i == 0), 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.qv !== 1'b1 || bus.q !== 8'h07 || bus.perr !== 1'b0) begin
            bad++;
            $display("FAIL parity good: qv=%b q=%h perr=%b want 1 07 0", bus.qv, bus.q, bus.perr);
        end
        for (int i = 0; i < int'(W); i++) cycle(1'b1, ser_bit(8'h07, 1'b0, i), (i == 0), 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.qv !== 1'b0 || bus.perr !== 1'b1) begin
            bad++;
            $display("FAIL parity bad: qv=%b perr=%b want 0 1", bus.qv, bus.perr);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.perr !== 1'b0 || bus.qv !== 1'b0) begin
            bad++;
            $display("FAIL parity once: perr=%b qv=%b want 0 0", bus.perr, bus.qv);
        end
    endtask
`endif

    task automatic test_random();
        logic sen, sfrm;
        for (int n = 0; n < 600; n++) begin
            sen  = ($urandom_range(3) != 0);
            sfrm = (bits.size() == 0) ? ($urandom_range(4) != 0) : ($urandom_range(29) == 0);
            cycle(sen, 1'($urandom_range(1)), sfrm, 1'($urandom_range(1)), 1'($urandom_range(1)));
            total++;
            if (bus.qv !== exp_qv || bus.q !== exp_q) begin
                bad++;
                $display("FAIL random out n%0d: qv=%b q=%h want qv=%b q=%h", n, bus.qv, bus.q, exp_qv, exp_q);
            end
            total++;
            if (bus.ovf !== e_ovf || bus.ferr !== e_ferr || bus.perr !== e_perr) begin
                bad++;
                $display("FAIL random pulses n%0d: ovf/ferr/perr=%b%b%b want %b%b%b",
                         n, bus.ovf, bus.ferr, bus.perr, e_ovf, e_ferr, e_perr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_order(1'b0, 8'h0D);
        test_order(1'b1, 8'hB0);
        test_overflow();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef SHIFT_RECEIVER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
